// File: rtl/clz_seq_if.sv
// Request/response bundle between execute control and the CLZ/CLO sequencer.
interface clz_seq_if;
    logic        start;
    logic        op_clo;
    logic [31:0] operand;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op_clo, operand, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op_clo, operand, flush,
        output busy, done, result
    );
endinterface

// File: rtl/clz_seq_ctrl.sv
// Multi-cycle count-leading-zeros/ones sequencer: scans one byte per cycle from the MSB end,
// stops at the first non-zero byte and reports the count with a one-cycle done pulse.
module clz_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    clz_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] data_reg;
    logic [1:0]  idx_reg;
    logic [5:0]  cnt_reg;
    logic [5:0]  result_reg;

    logic [7:0]  byte_arr [4];
    logic [7:0]  cur_byte;
    logic        byte_hit;
    logic [2:0]  lz8;
    logic        lz_found;
    logic        accept;
    logic        busy_c;
    logic        done_c;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_arr[gi] = data_reg[8*gi +: 8];
        end
    endgenerate

    assign cur_byte = byte_arr[idx_reg];
    assign byte_hit = |cur_byte;

    // Leading zeros inside the selected byte; only meaningful when byte_hit is set.
    always_comb begin
        lz8      = 3'd0;
        lz_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!lz_found) begin
                if (cur_byte[i]) lz_found = 1'b1;
                else             lz8 = lz8 + 3'd1;
            end
        end
    end

    // A request is only taken while not scanning, and never alongside a flush.
    assign accept = bus.start && !bus.flush && (state_reg != ST_SCAN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (bus.flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: state_next = bus.start ? ST_SCAN : ST_IDLE;
                ST_SCAN:          state_next = (byte_hit || idx_reg == 2'd0) ? ST_DONE : ST_SCAN;
                default:          state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_c = (state_reg == ST_SCAN);
        done_c = (state_reg == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg   <= 32'd0;
            idx_reg    <= 2'd0;
            cnt_reg    <= 6'd0;
            result_reg <= 6'd0;
        end else if (accept) begin
            data_reg <= bus.op_clo ? ~bus.operand : bus.operand;
            idx_reg  <= 2'd3;
            cnt_reg  <= 6'd0;
        end else if (state_reg == ST_SCAN && !bus.flush) begin
            if (byte_hit) begin
                result_reg <= cnt_reg + {3'd0, lz8};
            end else if (idx_reg != 2'd0) begin
                cnt_reg <= cnt_reg + 6'd8;
                idx_reg <= idx_reg - 2'd1;
            end else begin
                result_reg <= 6'd32;
            end
        end
    end

    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
    assign bus.result = {26'd0, result_reg};

endmodule

// File: tb/tb_clz_seq_ctrl.sv
// Randomised and directed check of clz_seq_ctrl against a bit-counting reference model.
module tb_clz_seq_ctrl;

    logic clk;
    logic rst_n;
    int   total_cnt;
    int   bad_cnt;
    logic [31:0] last_result;

    clz_seq_if bus ();

    clz_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: walk bits from the MSB, counting those equal to the counted value.
    function automatic int ref_count(input logic clo, input logic [31:0] v);
        int n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i] != clo) break;
            n++;
        end
        return n;
    endfunction

    function automatic int ref_k(input int n);
        return (n >= 32) ? 4 : (n / 8) + 1;
    endfunction

    // Called at a negedge with the DUT idle or in DONE; returns at the negedge after done.
    task automatic run_op(input string tag, input logic clo, input logic [31:0] v);
        int n, k, busy_cycles;
        n = ref_count(clo, v);
        k = ref_k(n);
        bus.start   = 1'b1;
        bus.op_clo  = clo;
        bus.operand = v;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cycles = 0;
        while (bus.busy === 1'b1 && busy_cycles < 10) begin
            busy_cycles++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 32'(busy_cycles), 32'(k));
        chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, " result"}, bus.result, 32'(n));
        $display("op %s clo=%0d operand=0x%08h result=%0d k=%0d", tag, clo, v, bus.result, busy_cycles);
        last_result = 32'(n);
        @(negedge clk);
        chk({tag, " done_pulse_end"}, {31'd0, bus.done}, 32'd0);
    endtask

    logic exp_busy [8];
    logic exp_done [8];
    int   done_pulses;

    initial begin
        total_cnt   = 0;
        bad_cnt     = 0;
        last_result = 32'd0;
        bus.start   = 1'b0;
        bus.op_clo  = 1'b0;
        bus.operand = 32'd0;
        bus.flush   = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk("reset busy", {31'd0, bus.busy}, 32'd0);
        chk("reset done", {31'd0, bus.done}, 32'd0);
        chk("reset result", bus.result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed corner cases
        run_op("clz_80000000", 1'b0, 32'h8000_0000);
        run_op("clo_7fffffff", 1'b1, 32'h7FFF_FFFF);
        run_op("clz_00000000", 1'b0, 32'h0000_0000);
        run_op("clo_ffffffff", 1'b1, 32'hFFFF_FFFF);
        run_op("clz_00010000", 1'b0, 32'h0001_0000);
        run_op("clz_00000001", 1'b0, 32'h0000_0001);
        run_op("clo_fffff0ff", 1'b1, 32'hFFFF_F0FF);

        // Back-to-back: start held through SCAN (ignored) and DONE (accepted)
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        done_pulses = 0;
        bus.start   = 1'b1;
        bus.op_clo  = 1'b0;
        bus.operand = 32'h0000_1000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("b2b busy c%0d", i), {31'd0, bus.busy}, {31'd0, exp_busy[i]});
            chk($sformatf("b2b done c%0d", i), {31'd0, bus.done}, {31'd0, exp_done[i]});
            if (bus.done === 1'b1) begin
                done_pulses++;
                chk($sformatf("b2b result c%0d", i), bus.result, (done_pulses == 1) ? 32'd19 : 32'd1);
            end
            if (i == 0) bus.operand = 32'h4000_0000;
            if (i == 4) bus.start = 1'b0;
        end
        chk("b2b done_pulses", 32'(done_pulses), 32'd2);
        $display("b2b ops results 19,1 done_pulses=%0d", done_pulses);
        last_result = 32'd1;

        // Flush in the second SCAN cycle
        bus.start   = 1'b1;
        bus.operand = 32'h0000_0000;
        @(negedge clk);
        bus.start = 1'b0;
        chk("flush scan1 busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        chk("flush scan2 busy", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush busy_drop", {31'd0, bus.busy}, 32'd0);
        done_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.done === 1'b1) done_pulses++;
            @(negedge clk);
        end
        chk("flush no_done", 32'(done_pulses), 32'd0);
        chk("flush result_kept", bus.result, last_result);
        $display("flush mid-scan result=%0d", bus.result);

        // start together with flush is dropped
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("start_flush busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        chk("start_flush busy2", {31'd0, bus.busy}, 32'd0);
        chk("start_flush done", {31'd0, bus.done}, 32'd0);
        $display("start+flush dropped busy=%0d", bus.busy);

        // Asynchronous reset between edges mid-SCAN
        bus.start   = 1'b1;
        bus.operand = 32'h0000_0000;
        @(negedge clk);
        bus.start = 1'b0;
        chk("arst pre busy", {31'd0, bus.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy", {31'd0, bus.busy}, 32'd0);
        chk("arst done", {31'd0, bus.done}, 32'd0);
        chk("arst result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1 || bus.done === 1'b1) done_pulses++;
        end
        chk("arst stays_idle", 32'(done_pulses), 32'd0);
        $display("async reset mid-scan result=%0d", bus.result);

        // Randomised operations with spread-out leading-count distribution
        for (int t = 0; t < 40; t++) begin
            logic        clo;
            logic [31:0] v;
            clo = 1'($urandom_range(0, 1));
            v   = $urandom;
            v   = v >> $urandom_range(0, 32);
            if (clo) v = ~v;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op($sformatf("rnd%0d", t), clo, v);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
